linear_layer_start_token_reader: RTL and testbench

Consumer-side controller for the Linear_Layer start-propagation FIFOs: it pops start tokens from a first-word-fall-through start FIFO (shift-register storage, read data valid whenever the FIFO is non-empty) and converts them into the `ap_start`/`ap_ready`/`ap_done` handshake of one downstream PE instance. It bounds the number of started-but-unfinished PE invocations and optionally keeps start/done statistics. It sits between a `start_for_*` FIFO and the PE it gates.

---
 rtl/linear_layer_start_token_reader.sv | 140 ++++++++++++++
 tb/tb_linear_layer_start_token_reader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/linear_layer_start_token_reader.sv
// linear_layer_start_token_reader
// Pops start tokens from a first-word-fall-through start FIFO and turns them
// into the ap_start/ap_ready/ap_done handshake of one downstream PE. It limits
// the number of started-but-unfinished invocations and flags stray dones.
// Optional feature macro: START_TOKEN_STATS_EN adds start/done counters;
// without it both counter outputs are tied to zero.
module linear_layer_start_token_reader #(
    parameter int DATA_WIDTH      = 1,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_empty_n,
    input  logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_read,
    output logic                  ap_start,
    input  logic                  ap_ready,
    input  logic                  ap_done,
    output logic [DATA_WIDTH-1:0] token,
    output logic [3:0]            outstanding,
    output logic                  busy,
    output logic                  err,
    output logic [CNT_WIDTH-1:0]  start_count,
    output logic [CNT_WIDTH-1:0]  done_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        START = 1'b1
    } state_t;

    localparam logic [4:0] MaxOut = 5'(MAX_OUTSTANDING);

    state_t                r_state;
    logic                  r_apStart;
    logic [DATA_WIDTH-1:0] r_token;
    logic [3:0]            r_outstanding;
    logic                  r_err;

    logic                  w_accept;
    logic                  w_doneValid;
    logic                  w_errEvent;
    logic [4:0]            w_nextOutstanding;
    logic                  w_room;
    logic                  w_pop;

    // Capacity is judged on the count as it will be after this cycle's accept
    // and done, so a slot freed by a done can be refilled in the same cycle.
    always_comb begin
        w_accept          = r_apStart & ap_ready;
        w_doneValid       = ap_done & (r_outstanding != 4'd0);
        w_errEvent        = ap_done & (r_outstanding == 4'd0) & ~w_accept;
        w_nextOutstanding = {1'b0, r_outstanding} + {4'd0, w_accept} - {4'd0, w_doneValid};
        w_room            = (w_nextOutstanding < MaxOut);
        w_pop             = if_empty_n & w_room & ((r_state == IDLE) | w_accept);
    end

    assign if_read     = w_pop & ~reset;
    assign ap_start    = r_apStart;
    assign token       = r_token;
    assign outstanding = r_outstanding;
    assign err         = r_err;
    assign busy        = r_apStart | (r_outstanding != 4'd0);

    // Start handshake FSM: a popped token is held with ap_start high until the
    // PE accepts it, and a new pop on the accepting cycle gives back-to-back starts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_apStart <= 1'b0;
            r_token   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_token   <= if_dout;
                        r_apStart <= 1'b1;
                        r_state   <= START;
                    end
                end
                START: begin
                    if (ap_ready) begin
                        if (w_pop) begin
                            r_token <= if_dout;
                        end else begin
                            r_apStart <= 1'b0;
                            r_state   <= IDLE;
                        end
                    end
                end
                default: begin
                    r_apStart <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    // Track started-but-unfinished invocations and latch a done that arrives
    // with nothing in flight as a sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_outstanding <= 4'd0;
            r_err         <= 1'b0;
        end else begin
            r_outstanding <= w_nextOutstanding[3:0];
            if (w_errEvent) begin
                r_err <= 1'b1;
            end
        end
    end

`ifdef START_TOKEN_STATS_EN
    logic [CNT_WIDTH-1:0] r_startCount;
    logic [CNT_WIDTH-1:0] r_doneCount;

    // Free-running statistics of accepted starts and completed invocations.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_startCount <= '0;
            r_doneCount  <= '0;
        end else begin
            if (w_accept) begin
                r_startCount <= r_startCount + 1'b1;
            end
            if (w_doneValid) begin
                r_doneCount <= r_doneCount + 1'b1;
            end
        end
    end

    assign start_count = r_startCount;
    assign done_count  = r_doneCount;
`else
    assign start_count = '0;
    assign done_count  = '0;
`endif

endmodule

// File: tb/tb_linear_layer_start_token_reader.sv
// Testbench for linear_layer_start_token_reader.
// A queue models the start FIFO; every token pushed into it is also pushed to
// an expected-token queue that is popped whenever the PE accepts a start.
module tb_linear_layer_start_token_reader;

    localparam int DW = 8;

`ifdef START_TOKEN_STATS_EN
    localparam bit StatsEn = 1'b1;
`else
    localparam bit StatsEn = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          ifEmptyN;
    logic [DW-1:0] ifDout;
    logic          ifRead;
    logic          apStart;
    logic          apReady;
    logic          apDone;
    logic [DW-1:0] token;
    logic [3:0]    outstanding;
    logic          busy;
    logic          err;
    logic [15:0]   startCount;
    logic [15:0]   doneCount;

    logic [DW-1:0] fifoQ[$];
    logic [DW-1:0] expQ[$];

    int compareCount  = 0;
    int mismatchCount = 0;
    int readCount     = 0;
    int acceptCount   = 0;
    int apStartCycles = 0;

    linear_layer_start_token_reader #(
        .DATA_WIDTH(DW),
        .MAX_OUTSTANDING(4),
        .CNT_WIDTH(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .if_empty_n(ifEmptyN),
        .if_dout(ifDout),
        .if_read(ifRead),
        .ap_start(apStart),
        .ap_ready(apReady),
        .ap_done(apDone),
        .token(token),
        .outstanding(outstanding),
        .busy(busy),
        .err(err),
        .start_count(startCount),
        .done_count(doneCount)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] expCnt(input int n);
        return StatsEn ? 32'(n) : 32'd0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic pushToken(input logic [DW-1:0] t);
        fifoQ.push_back(t);
        expQ.push_back(t);
    endtask

    // One clock cycle: drive inputs at the falling edge, sample just after,
    // then advance the FIFO model across the rising edge.
    task automatic applyStimulus(input logic rdy, input logic done, input logic fifoEn);
        logic          sawRead;
        logic [DW-1:0] expTok;
        apReady  = rdy;
        apDone   = done;
        ifEmptyN = fifoEn && (fifoQ.size() != 0);
        ifDout   = ifEmptyN ? fifoQ[0] : '0;
        #1;
        sawRead = ifRead;
        if (apStart) apStartCycles++;
        if (ifRead && !ifEmptyN) checkOutput("readWhenEmpty", 32'(ifRead), 32'd0);
        if (apStart && rdy) begin
            acceptCount++;
            if (expQ.size() == 0) begin
                checkOutput("acceptWithoutToken", 32'd1, 32'd0);
            end else begin
                expTok = expQ.pop_front();
                checkOutput("token", 32'(token), 32'(expTok));
            end
        end
        @(posedge clk);
        if (sawRead && fifoQ.size() != 0) begin
            readCount++;
            void'(fifoQ.pop_front());
        end
        @(negedge clk);
    endtask

    // Directed sequence covering reset, single start, back-pressure by the
    // outstanding limit, refill on done, simultaneous accept/done, stray done
    // and reset while a start is pending.
    initial begin
        int r0, a0, s0;
        reset    = 1'b1;
        ifEmptyN = 1'b1;
        ifDout   = 8'h99;
        apReady  = 1'b0;
        apDone   = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_ifRead", 32'(ifRead), 32'd0);
        checkOutput("rst_apStart", 32'(apStart), 32'd0);
        checkOutput("rst_outstanding", 32'(outstanding), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_token", 32'(token), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Single token, ready two cycles after ap_start rises, done five later.
        pushToken(8'h01);
        r0 = readCount; s0 = apStartCycles;
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("t1_apStartRise", 32'(apStart), 32'd1);
        checkOutput("t1_busy", 32'(busy), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("t1_outstanding1", 32'(outstanding), 32'd1);
        checkOutput("t1_apStartLow", 32'(apStart), 32'd0);
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("t1_reads", 32'(readCount - r0), 32'd1);
        checkOutput("t1_apStartCycles", 32'(apStartCycles - s0), 32'd3);
        checkOutput("t1_outstanding0", 32'(outstanding), 32'd0);
        checkOutput("t1_startCount", 32'(startCount), expCnt(1));
        checkOutput("t1_doneCount", 32'(doneCount), expCnt(1));

        // Eight tokens, ready held high, no done: four starts then stall.
        for (int i = 0; i < 8; i++) pushToken(8'(8'h10 + i));
        applyStimulus(1'b1, 1'b0, 1'b1);
        a0 = acceptCount;
        repeat (4) applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("t2_consecutiveStarts", 32'(acceptCount - a0), 32'd4);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("t2_noMoreStarts", 32'(acceptCount - a0), 32'd4);
        checkOutput("t2_apStart", 32'(apStart), 32'd0);
        checkOutput("t2_outstanding", 32'(outstanding), 32'd4);
        checkOutput("t2_fifoLeft", 32'(fifoQ.size()), 32'd4);

        // Done at the limit with a token waiting refills in the same cycle.
        r0 = readCount; a0 = acceptCount;
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("t3_readOnDone", 32'(readCount - r0), 32'd1);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("t3_oneStart", 32'(acceptCount - a0), 32'd1);
        checkOutput("t3_outstanding", 32'(outstanding), 32'd4);
        checkOutput("t3_startCount", 32'(startCount), expCnt(6));

        // Accept and done in the same cycle with two outstanding.
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("t4_outstandingBefore", 32'(outstanding), 32'd2);
        checkOutput("t4_doneBefore", 32'(doneCount), expCnt(4));
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("t4_outstandingAfter", 32'(outstanding), 32'd2);
        checkOutput("t4_startCount", 32'(startCount), expCnt(7));
        checkOutput("t4_doneCount", 32'(doneCount), expCnt(5));
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        repeat (4) applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("t4_drained", 32'(outstanding), 32'd0);
        checkOutput("t4_expEmpty", 32'(expQ.size()), 32'd0);
        checkOutput("t4_startTotal", 32'(startCount), expCnt(9));
        checkOutput("t4_doneTotal", 32'(doneCount), expCnt(9));
        checkOutput("t4_errClear", 32'(err), 32'd0);
        checkOutput("t4_busyIdle", 32'(busy), 32'd0);

        // Stray done with nothing outstanding sets a sticky error.
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("t5_err", 32'(err), 32'd1);
        checkOutput("t5_outstanding", 32'(outstanding), 32'd0);
        checkOutput("t5_doneCount", 32'(doneCount), expCnt(9));
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("t5_errSticky", 32'(err), 32'd1);

        // Reset while a start waits on ready.
        pushToken(8'hA5);
        pushToken(8'h3C);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("t6_pending", 32'(apStart), 32'd1);
        checkOutput("t6_outstandingPre", 32'(outstanding), 32'd1);
        pushToken(8'h77);
        reset    = 1'b1;
        ifEmptyN = 1'b1;
        ifDout   = fifoQ[0];
        #1;
        checkOutput("t6_rstApStart", 32'(apStart), 32'd0);
        checkOutput("t6_rstIfRead", 32'(ifRead), 32'd0);
        checkOutput("t6_rstOutstanding", 32'(outstanding), 32'd0);
        checkOutput("t6_rstErr", 32'(err), 32'd0);
        checkOutput("t6_rstStartCount", 32'(startCount), 32'd0);
        checkOutput("t6_rstBusy", 32'(busy), 32'd0);
        void'(expQ.pop_front());
        @(negedge clk);
        reset = 1'b0;
        r0 = readCount;
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t6_noPopWhileEmpty", 32'(readCount - r0), 32'd0);
        checkOutput("t6_idleAfterReset", 32'(apStart), 32'd0);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("t6_popAfterReset", 32'(readCount - r0), 32'd1);
        checkOutput("t6_outstandingPost", 32'(outstanding), 32'd1);
        checkOutput("t6_startCountPost", 32'(startCount), expCnt(1));
        checkOutput("t6_doneCountPost", 32'(doneCount), expCnt(0));
        checkOutput("t6_expEmpty", 32'(expQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
